arb_grant_hold: RTL and testbench
=================================

// Module: arb_grant_hold
//
// PURPOSE
// - Grant stage directly downstream of the one-hot priority selector in the
//   bus arbiter.
// - Registers the selector's one-hot candidate as the bus grant and holds it
//   until the owning master's transfer completes.
// - Returns "canchange" to the selector so that the selection policy can
//   rotate for fairness.
// - Bounds bus tenure with a hold counter so that a locked or chained master
//   cannot starve the others.
//
// PARAMETERS
// - W_REQ    default 4    number of requesting masters; one-hot width
// - MAX_HOLD default 16   back-to-back transfers allowed before canchange is
//                         forced; must be >= 1
// - W_ID     default 2    width of gnt_id; must be >= $clog2(W_REQ)
//
// PORTS
// - clk        input   1       single clock; all state is on its rising edge
// - rst        input   1       reset; asynchronous, active-high
// - req        input   W_REQ   request bitmap, one bit per master
// - cand       input   W_REQ   one-hot (or zero) candidate from the priority selector
// - xfer_done  input   1       current owner's final beat is accepted this cycle
// - lock       input   1       owner requests that the bus is not released after xfer_done
// - canchange  output  1       drives the selector's canchange input
// - gnt        output  W_REQ   registered one-hot grant
// - gnt_valid  output  1       gnt is nonzero
// - gnt_id     output  W_ID    binary index of gnt; 0 when gnt_valid = 0
//
// BEHAVIOUR
// - Reset (async, rst = 1): state IDLE, gnt = 0, gnt_valid = 0, gnt_id = 0,
//   hold_cnt = 0, canchange = 1.
// - Candidate qualification:
//     cand_ok = (cand != 0) && ((cand & req) == cand) && onehot(cand)
//   A non-one-hot cand is ignored and never granted. The bench asserts that
//   this never happens.
// - IDLE:
//   - canchange = 1.
//   - If cand_ok: gnt <= cand, hold_cnt <= 0, go to BUSY.
//   - gnt becomes visible 1 cycle after cand; this is the only latency.
// - BUSY:
//   - gnt is stable.
//   - canchange = (hold_cnt == MAX_HOLD-1).
//   - Priority of events within one cycle:
//     1. Abandon, (req & gnt) == 0: go to IDLE, gnt <= 0, hold_cnt <= 0.
//        Takes effect even when xfer_done is set in the same cycle.
//     2. xfer_done && lock && hold_cnt < MAX_HOLD-1: stay BUSY,
//        hold_cnt <= hold_cnt + 1.
//     3. xfer_done otherwise:
//        - If cand_ok && cand != gnt: gnt <= cand, hold_cnt <= 0 (0-bubble
//          handover; stay BUSY).
//        - Else if cand_ok && cand == gnt: stay BUSY,
//          hold_cnt <= sat(hold_cnt + 1).
//        - Else: go to IDLE, gnt <= 0, hold_cnt <= 0.
//     4. No xfer_done: hold everything.
// - Saturation and release:
//   - hold_cnt saturates at MAX_HOLD-1 and never wraps.
//   - At saturation lock is ignored, and release and re-grant follow rule 3.
//   - The same master may win again only if the selector still picks it with
//     canchange = 1.
// - A transfer is never aborted by the arbiter: gnt changes only on
//   xfer_done, on abandon, or from IDLE.
// - xfer_done in IDLE is ignored. lock in IDLE is ignored.
// - Outputs:
//   - gnt, gnt_id and gnt_valid are all registered.
//   - canchange is combinational from the state and hold_cnt only, not from
//     req or cand, so there is no combinational loop with the selector.
//
// STRUCTURE
// - Shared package: state encoding {IDLE, BUSY} and the W_REQ/W_ID defaults
//   for the arbiter family.
// - One sub-module: onehot_to_bin (W_REQ -> W_ID). It is combinational and
//   also used by the bus mux; its output is registered as gnt_id.
// - Top level contains the FSM, hold_cnt ($clog2(MAX_HOLD)+1 bits) and the
//   grant register.
//
// TESTING (W_REQ = 4, MAX_HOLD = 4)
// - Reset then idle:
//   req = 0 -> gnt = 0, gnt_valid = 0, gnt_id = 0, canchange = 1.
//   Assert rst mid-BUSY -> gnt = 0 in the same cycle.
// - Simple grant: req = 'b0100, cand = 'b0100 at cycle t -> gnt = 'b0100,
//   gnt_id = 2 at t+1. xfer_done with req = 0 -> gnt = 0 at the next edge.
// - Handover: owner 'b0001, cand = 'b1000, xfer_done = 1 -> gnt = 'b1000 the
//   next cycle, with no idle cycle.
// - Lock limit: owner 'b0010 with lock = 1 and xfer_done every cycle.
//   -> canchange rises after 3 transfers; the 4th xfer_done with
//   cand = 'b0001 -> gnt = 'b0001.
// - Abandon: owner 'b0100 drops req without xfer_done -> gnt = 0 and state
//   IDLE the next cycle; same when req drops in the xfer_done cycle.
// - Illegal candidate: cand = 'b0110 or cand not in req while IDLE
//   -> no grant; gnt stays 0.

Source files
------------

// File: rtl/arb_grant_hold_pkg.sv
// rtl/arb_grant_hold_pkg.sv - shared state encoding and widths for the arbiter family
package arb_grant_hold_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int W_REQ_DEF = 4;
  localparam int W_ID_DEF  = 2;

endpackage

// File: rtl/arb_grant_hold_onehot_to_bin.sv
// rtl/arb_grant_hold_onehot_to_bin.sv - one-hot to binary index encoder, zero in gives zero out
module onehot_to_bin
  import arb_grant_hold_pkg::*;
#(
  parameter int W_REQ = W_REQ_DEF,
  parameter int W_ID  = W_ID_DEF
) (
  input  logic [W_REQ-1:0] onehot,
  output logic [W_ID-1:0]  bin
);

  // OR of the indices of set bits; exact for one-hot input, 0 for zero input
  always_comb begin
    bin = '0;
    for (int i = 0; i < W_REQ; i++) begin
      if (onehot[i]) bin = bin | W_ID'(i);
    end
  end

endmodule

// File: rtl/arb_grant_hold.sv
// rtl/arb_grant_hold.sv - registers the selector's candidate as bus grant and bounds tenure
module arb_grant_hold
  import arb_grant_hold_pkg::*;
#(
  parameter int W_REQ    = W_REQ_DEF,
  parameter int MAX_HOLD = 16,
  parameter int W_ID     = W_ID_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_REQ-1:0] req,
  input  logic [W_REQ-1:0] cand,
  input  logic             xfer_done,
  input  logic             lock,
  output logic             canchange,
  output logic [W_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [W_ID-1:0]  gnt_id
);

  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic [W_ID-1:0] cand_id;
  logic            cand_ok;
  logic            owner_req;

  onehot_to_bin #(
    .W_REQ (W_REQ),
    .W_ID  (W_ID)
  ) u_cand_enc (
    .onehot (cand),
    .bin    (cand_id)
  );

  assign cand_ok   = (cand != '0) && ((cand & req) == cand) &&
                     ((cand & (cand - 1'b1)) == '0);
  assign owner_req = (req & gnt) != '0;

  // Depends only on state and hold_cnt so the selector loop stays acyclic
  assign canchange = (state == IDLE) || (hold_cnt == HOLD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_ok) begin
            state     <= BUSY;
            gnt       <= cand;
            gnt_valid <= 1'b1;
            gnt_id    <= cand_id;
            hold_cnt  <= '0;
          end
        end
        BUSY: begin
          if (!owner_req) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            hold_cnt  <= '0;
          end else if (xfer_done) begin
            if (lock && (hold_cnt < HOLD_MAX)) begin
              hold_cnt <= hold_cnt + 1'b1;
            end else if (cand_ok && (cand != gnt)) begin
              gnt      <= cand;
              gnt_id   <= cand_id;
              hold_cnt <= '0;
            end else if (cand_ok) begin
              if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
              gnt_id    <= '0;
              hold_cnt  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_grant_hold.sv
// tb/tb_arb_grant_hold.sv - directed table, corner sequences and randomized model check
module tb_arb_grant_hold;

  localparam int W_REQ    = 4;
  localparam int MAX_HOLD = 4;
  localparam int W_ID     = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [W_REQ-1:0] req = '0;
  logic [W_REQ-1:0] cand = '0;
  logic             xfer_done = 1'b0;
  logic             lock = 1'b0;
  logic             canchange;
  logic [W_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [W_ID-1:0]  gnt_id;

  int n_tests = 0;
  int n_fail  = 0;

  arb_grant_hold #(
    .W_REQ    (W_REQ),
    .MAX_HOLD (MAX_HOLD),
    .W_ID     (W_ID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .cand      (cand),
    .xfer_done (xfer_done),
    .lock      (lock),
    .canchange (canchange),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] cand;
    logic       xd;
    logic       lk;
    logic [3:0] exp_gnt;
    logic       exp_cc;
  } vec_t;

  vec_t vecs[19];

  // Reference model: owner index (-1 = bus free) and transfers since grant
  int m_owner = -1;
  int m_ten   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] eg, input logic ecc);
    logic [31:0] eid;
    eid = 0;
    for (int i = 0; i < W_REQ; i++) if (eg[i]) eid = i;
    check({tag, " gnt"},       32'(gnt),       32'(eg));
    check({tag, " gnt_valid"}, 32'(gnt_valid), 32'(eg != 0));
    check({tag, " gnt_id"},    32'(gnt_id),    eid);
    check({tag, " canchange"}, 32'(canchange), 32'(ecc));
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] c, input logic xd, input logic lk);
    req = r; cand = c; xfer_done = xd; lock = lk;
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [3:0] r, input logic [3:0] c);
    return (c != 0) && ($countones(c) == 1) && ((c & ~r) == 0);
  endfunction

  function automatic int idx_of(input logic [3:0] c);
    for (int i = 0; i < W_REQ; i++) if (c[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic [3:0] c, input logic xd, input logic lk);
    if (m_owner < 0) begin
      if (legal(r, c)) begin
        m_owner = idx_of(c);
        m_ten   = 0;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (xd) begin
      if (lk && m_ten < MAX_HOLD - 1) m_ten++;
      else if (legal(r, c) && idx_of(c) != m_owner) begin
        m_owner = idx_of(c);
        m_ten   = 0;
      end else if (legal(r, c)) begin
        if (m_ten < MAX_HOLD - 1) m_ten++;
      end else m_owner = -1;
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0110, 4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[2]  = '{4'b0010, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[3]  = '{4'b0100, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0};
    vecs[4]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0};
    vecs[5]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[6]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0};
    vecs[7]  = '{4'b1001, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0};
    vecs[8]  = '{4'b1000, 4'b0000, 1'b0, 1'b0, 4'b1000, 1'b0};
    vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1};
    vecs[10] = '{4'b0010, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0};
    vecs[11] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0};
    vecs[12] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b0};
    vecs[13] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1};
    vecs[14] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1};
    vecs[15] = '{4'b0011, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0};
    vecs[16] = '{4'b0001, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0};
    vecs[17] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[18] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1};

    #1 rst = 1'b1;
    #2 check_outs("reset", 4'b0000, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check_outs("post_reset", 4'b0000, 1'b1);

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].req, vecs[i].cand, vecs[i].xd, vecs[i].lk);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_cc);
    end

    // Async reset while BUSY clears the grant before the next clock edge
    step(4'b0100, 4'b0100, 1'b0, 1'b0);
    check_outs("pre_rst_busy", 4'b0100, 1'b0);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 4'b0000, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    step(4'b0000, 4'b0000, 1'b0, 1'b0);
    check_outs("after_rst", 4'b0000, 1'b1);

    m_owner = -1;
    m_ten   = 0;
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] r;
      logic [3:0] c;
      logic       xd;
      logic       lk;
      logic [3:0] eg;
      r = 4'($urandom_range(0, 15));
      if (m_owner >= 0 && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
      c = 4'b0001 << $urandom_range(0, 3);
      if (r != 0 && $urandom_range(0, 1) == 1) begin
        while ((c & r) == 0) c = 4'b0001 << $urandom_range(0, 3);
      end
      if ($urandom_range(0, 5) == 0) c = 4'b0000;
      xd = ($urandom_range(0, 2) != 0);
      lk = $urandom_range(0, 1) == 1;
      model_step(r, c, xd, lk);
      step(r, c, xd, lk);
      eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
      check_outs($sformatf("rnd%0d", n), eg, (m_owner < 0) || (m_ten == MAX_HOLD - 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
